// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester/line bundle for the shared UART transmitter
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                      baud_tick;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        ack;
    logic [IDW-1:0]            grant_id;
    logic                      busy;
    logic                      tx;

    // Byte sources and baud generator side
    modport master (
        output baud_tick, req, data,
        input  ack, grant_id, busy, tx
    );

    // Scheduler/serializer side
    modport slave (
        input  baud_tick, req, data,
        output ack, grant_id, busy, tx
    );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin requester scheduler and 8N1 serializer
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_sched_if.slave   bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic               tx_q, tx_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;

    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     cand;
    logic               any_req;
    logic               grant;
    logic [DATA_W-1:0]  sel_byte;
    logic               tick;

    assign tick = bus.baud_tick;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        winner  = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!any_req && bus.req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    // Byte of the current winner
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_byte = bus.data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State and datapath registers; reset drops the line to idle at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= 1'b1;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            ack_q        <= ack_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE and at the end of STOP
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) state_d = START;
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick && bit_cnt_q == 3'(DATA_W - 1)) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (any_req) begin
                        grant   = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: grant latching, bit shifting, line level
    always_comb begin
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        tx_d         = tx_q;
        ack_d        = '0;
        if (grant) begin
            shift_d        = sel_byte;
            grant_id_d     = winner;
            last_grant_d   = winner;
            ack_d[winner]  = 1'b1;
        end
        case (state_q)
            IDLE: tx_d = 1'b1;
            WAIT_TICK: begin
                if (tick) tx_d = 1'b0;
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'(DATA_W - 1)) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) tx_d = !any_req;
            end
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for the UART transmit scheduler
module tb_uart_tx_sched;
    localparam int NR = 4;
    localparam int DW = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic tick_prev = 1'b0;

    uart_tx_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int         exp_ack_q[$];
    logic [7:0] exp_byte_q[$];
    bit         exp_b2b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int id, input logic [7:0] b, input bit b2b, input bit with_ack);
        if (with_ack) exp_ack_q.push_back(id);
        exp_byte_q.push_back(b);
        exp_b2b_q.push_back(b2b);
    endtask

    // Baud tick: one clk pulse every 4 clocks
    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 bus.baud_tick = 1'b1;
            @(posedge clk);
            #1 bus.baud_tick = 1'b0;
        end
    end

    always @(posedge clk) tick_prev <= bus.baud_tick;

    // Ack monitor
    int e_ack;
    always @(negedge clk) begin
        if (reset_n && bus.ack != '0) begin
            if (exp_ack_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ack_unexpected: got %0h expected none", bus.ack);
            end else begin
                e_ack = exp_ack_q.pop_front();
                check("ack_onehot", 32'(bus.ack), 32'd1 << e_ack);
                check("ack_grant_id", 32'(bus.grant_id), e_ack);
                check("ack_busy", 32'(bus.busy), 1);
            end
        end
    end

    // Serial frame monitor: samples the line once per bit period
    bit         in_frame  = 1'b0;
    bit         busy_ok   = 1'b0;
    bit         b2b_exp;
    int         gap       = 100;
    int         start_gap = 100;
    int         bitn      = 0;
    logic [7:0] rx        = '0;
    logic [7:0] eb;
    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame = 1'b0;
            gap      = 100;
        end else if (tick_prev) begin
            if (!in_frame) begin
                if (bus.tx == 1'b0) begin
                    in_frame  = 1'b1;
                    bitn      = 0;
                    busy_ok   = bus.busy;
                    start_gap = gap;
                end else if (gap < 1000) begin
                    gap++;
                end
            end else if (bitn < 8) begin
                rx[bitn] = bus.tx;
                busy_ok  = busy_ok & bus.busy;
                bitn++;
            end else begin
                in_frame = 1'b0;
                gap      = 0;
                check("stop_bit", 32'(bus.tx), 1);
                if (exp_byte_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got %0h expected none", rx);
                end else begin
                    eb      = exp_byte_q.pop_front();
                    b2b_exp = exp_b2b_q.pop_front();
                    check("frame_byte", 32'(rx), 32'(eb));
                    check("frame_busy", 32'(busy_ok & bus.busy), 1);
                    if (b2b_exp) check("frame_gap", start_gap, 0);
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check(name, 32'(bus.busy), 0);
    endtask

    task automatic serve(input logic [3:0] mask);
        bus.req = bus.req | mask;
        for (int i = 0; i < 400; i++) begin
            if ((bus.req & mask) == 4'b0000) break;
            @(negedge clk);
            bus.req = bus.req & ~bus.ack;
        end
        check("serve_done", 32'(bus.req & mask), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int         nacks;
    logic [3:0] pend;
    bit         got;
    int         cnt;

    initial begin
        bus.req  = '0;
        bus.data = '0;

        // Reset state, checked before any clock edge
        #2 reset_n = 1'b0;
        #1;
        check("rst_tx", 32'(bus.tx), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_grant_id", 32'(bus.grant_id), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, byte A5 -> line 0,1,0,1,0,0,1,0,1,1
        bus.data[7:0] = 8'hA5;
        push_frame(0, 8'hA5, 1'b0, 1'b1);
        serve(4'b0001);
        wait_idle("t1_busy_drop");

        // Contention from reset: order 0,1,2,3,0, frames back-to-back
        pulse_reset();
        bus.data = {8'h13, 8'h12, 8'h11, 8'h10};
        push_frame(0, 8'h10, 1'b0, 1'b1);
        push_frame(1, 8'h11, 1'b1, 1'b1);
        push_frame(2, 8'h12, 1'b1, 1'b1);
        push_frame(3, 8'h13, 1'b1, 1'b1);
        push_frame(0, 8'h10, 1'b1, 1'b1);
        bus.req = 4'hF;
        nacks   = 0;
        pend    = '0;
        for (int i = 0; i < 600 && nacks < 5; i++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                nacks++;
                bus.req = bus.req & ~bus.ack;
                pend    = bus.ack;
                if (nacks == 5) bus.req = '0;
            end else if (pend != '0) begin
                bus.req = bus.req | pend;
                pend    = '0;
            end
        end
        check("t2_acks", nacks, 5);
        wait_idle("t2_busy_drop");

        // Round-robin pointer: 2 alone, then 0 and 2 -> 0 first
        bus.data[23:16] = 8'h5C;
        push_frame(2, 8'h5C, 1'b0, 1'b1);
        serve(4'b0100);
        wait_idle("t3a_busy_drop");
        bus.data[7:0]   = 8'h3E;
        bus.data[23:16] = 8'hC3;
        push_frame(0, 8'h3E, 1'b0, 1'b1);
        push_frame(2, 8'hC3, 1'b1, 1'b1);
        serve(4'b0101);
        wait_idle("t3b_busy_drop");

        // Back-to-back from STOP: req[1] raised during requester 3's data bits
        bus.data[31:24] = 8'h96;
        push_frame(3, 8'h96, 1'b0, 1'b1);
        serve(4'b1000);
        repeat (20) @(negedge clk);
        bus.data[15:8] = 8'h4B;
        push_frame(1, 8'h4B, 1'b1, 1'b1);
        bus.req[1] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ack[1]) begin
                check("t4_ack_after_tick", 32'(tick_prev), 1);
                check("t4_tx_start", 32'(bus.tx), 0);
                check("t4_busy", 32'(bus.busy), 1);
                bus.req[1] = 1'b0;
                got = 1'b1;
                break;
            end
        end
        check("t4_ack_seen", 32'(got), 1);
        wait_idle("t4_busy_drop");

        // Reset during data bit 4 of requester 2's frame (bit 4 of E7 is 0)
        bus.data[23:16] = 8'hE7;
        exp_ack_q.push_back(2);
        bus.req[2] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ack[2]) begin
                got = 1'b1;
                break;
            end
        end
        check("t5_ack_seen", 32'(got), 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tick_prev && bus.tx == 1'b0) break;
        end
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 5; i++) begin
            @(negedge clk);
            if (tick_prev) cnt++;
        end
        check("t5_pre_reset_tx", 32'(bus.tx), 0);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_tx", 32'(bus.tx), 1);
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_ack", 32'(bus.ack), 0);
        push_frame(2, 8'hE7, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        serve(4'b0100);
        wait_idle("t5_busy_drop");

        // Grant edge coincides with a tick: start bit at the following tick
        bus.data[31:24] = 8'h01;
        push_frame(3, 8'h01, 1'b0, 1'b1);
        @(posedge bus.baud_tick);
        bus.req[3] = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack[3]) bus.req[3] = 1'b0;
            if (bus.tx == 1'b0) begin
                cnt = i;
                break;
            end
        end
        check("t6_start_edge", cnt, 5);
        wait_idle("t6_busy_drop");

        repeat (4) @(negedge clk);
        check("ack_queue_empty", exp_ack_q.size(), 0);
        check("frame_queue_empty", exp_byte_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
